msg_sequencer: RTL and testbench
================================

Name: msg_sequencer

Overview:
Parametrised message sequencer. Each rising edge on push-button input M steps through a stored character message and shows the current character on msj_f. It generalises the single fixed-message FSM with:
- selectable messages
- configurable character width and message length
- loop or one-shot mode
- an input synchroniser and edge detector
- a soft clear
The block sits between the board push-button and the character display / debug LEDs.

Parameters:
CHAR_W, 8, width of one character (ASCII for 8).
MSG_LEN, 6, characters per message, ≥2.
NUM_MSGS, 2, number of stored messages, ≥1.
LOOP, 0, 1 = wrap to first character after last; 0 = one-shot, stop in DONE.

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset, asserted asynchronously, released synchronously by caller).
M  in  1  advance request, asynchronous button level; acted on at its rising edge only.
clr  in  1  synchronous soft clear, active-high.
msg_sel  in  $clog2(NUM_MSGS) (min 1)  message select, sampled only on the IDLE->SHOW step.
msj_f  out  CHAR_W  current character, registered.
idx  out  $clog2(MSG_LEN)  current character index, registered.
busy  out  1  high in SHOW.
done  out  1  high in DONE.
wrap  out  1  one-cycle pulse when LOOP=1 and idx wraps.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, msj_f=BLANK (all zeros), idx=0, busy=0, done=0, wrap=0.
  - Synchroniser flops and edge-history flop = 0.
  - msg_sel latch = 0.
- Input path: M goes through 2 flops (s1, s2) and then a history flop (s3). adv = s2 & ~s3.
  - If M rises before edge n, adv is high for the cycle after edge n+1, and outputs update at edge n+2 (3-edge latency).
  - Holding M high yields exactly one adv.
  - M pulses narrower than one clk period may be missed; this is acceptable.
- States and transitions:
  - IDLE: msj_f=BLANK.
    - adv -> SHOW, idx=0, sel_q=msg_sel, msj_f=ROM[msg_sel][0].
  - SHOW: msj_f=ROM[sel_q][idx].
    - adv with idx<MSG_LEN-1 -> idx+1.
    - adv with idx=MSG_LEN-1 and LOOP=1 -> idx=0, wrap=1 for one cycle, stay in SHOW.
    - adv with idx=MSG_LEN-1 and LOOP=0 -> DONE.
  - DONE: msj_f=END_CHAR (all ones), idx held at MSG_LEN-1, done=1.
    - adv -> IDLE.
- Priority: rst > clr > adv.
  - clr=1 forces IDLE outputs at the next edge, regardless of adv.
  - The synchroniser is not cleared by clr, so a level already high on M does not re-trigger.
- Changes to msg_sel during SHOW/DONE are ignored.
- msg_sel ≥ NUM_MSGS: treated as 0.
- Reset mid-message: immediate return to reset values. The next adv starts at idx 0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package msg_pkg holds:
  - state enum (IDLE, SHOW, DONE)
  - BLANK and END_CHAR constants
  - message ROM constant array [NUM_MSGS][MSG_LEN] of CHAR_W
  - defaults: msg 0 = "TALLER" (54 41 4C 4C 45 52), msg 1 = "FSM_OK" (46 53 4D 5F 4F 4B)
- Sub-module edge_sync: 2-flop synchroniser plus rising-edge pulse, with clk/rst and the same reset style.

Test Plan:
1. Reset then 6 M pulses with msg_sel=0, LOOP=0 -> msj_f 54,41,4C,4C,45,52, each 3 edges after the M rise. The 7th pulse gives FF with done=1; the 8th gives 00 (IDLE).
2. msg_sel=1, one pulse, then msg_sel=0 and 2 pulses -> msj_f 46, 53, 4D (selection latched).
3. LOOP=1, 7 pulses on msg 0 -> the 7th gives msj_f=54, idx=0, and wrap high for exactly one cycle.
4. Hold M high for 50 cycles -> exactly one advance. A 1-cycle-wide glitch aligned between edges -> at most one advance.
5. At idx=3, drive rst=0 between edges -> msj_f=00 and idx=0 immediately (before the next clk edge). After release, the next pulse gives 54.
6. clr and adv in the same cycle while in SHOW -> IDLE, msj_f=00. The next M pulse gives 54.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and the default message table for the push-button message sequencer.
package msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // BLANK is all zeros and END_CHAR all ones at any character width.
  localparam logic BLANK_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

  localparam int DEF_NUM_MSGS = 2;
  localparam int DEF_MSG_LEN  = 6;

  // Default ROM contents; the first character sits in the most significant byte.
  localparam logic [8*DEF_MSG_LEN-1:0] MSG0_TXT = "TALLER";
  localparam logic [8*DEF_MSG_LEN-1:0] MSG1_TXT = "FSM_OK";

  // Character of the default table; slots beyond it read as a space.
  function automatic logic [7:0] def_char(input int m, input int c);
    logic [7:0] ch;
    ch = 8'h20;
    if (c >= 0 && c < DEF_MSG_LEN) begin
      if (m == 0) begin
        ch = MSG0_TXT[(DEF_MSG_LEN-1-c)*8 +: 8];
      end else if (m == 1) begin
        ch = MSG1_TXT[(DEF_MSG_LEN-1-c)*8 +: 8];
      end
    end
    return ch;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/msg_sequencer.sv
// Steps through a stored message one character per button press and
// presents the current character, index and status on registered outputs.
module msg_sequencer
  import msg_pkg::*;
#(
  parameter int CHAR_W   = 8,
  parameter int MSG_LEN  = 6,
  parameter int NUM_MSGS = 2,
  parameter int LOOP     = 0,
  localparam int SEL_W   = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
  localparam int IDX_W   = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M,
  input  logic              clr,
  input  logic [SEL_W-1:0]  msg_sel,
  output logic [CHAR_W-1:0] msj_f,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  logic [CHAR_W-1:0] rom [NUM_MSGS][MSG_LEN];

  for (genvar gi = 0; gi < NUM_MSGS; gi++) begin : g_msg
    for (genvar gj = 0; gj < MSG_LEN; gj++) begin : g_chr
      assign rom[gi][gj] = CHAR_W'(def_char(gi, gj));
    end
  end

  logic adv;

  edge_sync u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (M),
    .pulse_o (adv)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CHAR_W-1:0] msj_q, msj_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic [SEL_W-1:0]  sel_safe;
  logic [IDX_W-1:0]  idx_inc;

  // Out-of-range selections fall back to message 0.
  assign sel_safe = (32'(msg_sel) >= NUM_MSGS) ? '0 : msg_sel;
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    msj_d   = msj_q;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      msj_d   = {CHAR_W{BLANK_BIT}};
    end else if (adv) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          sel_d   = sel_safe;
          msj_d   = rom[sel_safe][0];
        end
        ST_SHOW: begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_inc;
            msj_d = rom[sel_q][idx_inc];
          end else if (LOOP != 0) begin
            idx_d  = '0;
            wrap_d = 1'b1;
            msj_d  = rom[sel_q][0];
          end else begin
            state_d = ST_DONE;
            msj_d   = {CHAR_W{END_BIT}};
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          msj_d   = {CHAR_W{BLANK_BIT}};
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          msj_d   = {CHAR_W{BLANK_BIT}};
        end
      endcase
    end
    busy_d = (state_d == ST_SHOW);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      msj_q   <= {CHAR_W{BLANK_BIT}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      msj_q   <= msj_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign msj_f = msj_q;
  assign idx   = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench: a one-shot and a looping sequencer share the same stimulus.
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       M   = 1'b0;
  logic       clr = 1'b0;
  logic [0:0] msg_sel = 1'b0;

  logic [7:0] msj0, msj1;
  logic [2:0] idx0, idx1;
  logic       busy0, busy1, done0, done1, wrap0, wrap1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msg_sequencer #(.CHAR_W(8), .MSG_LEN(6), .NUM_MSGS(2), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .M(M), .clr(clr), .msg_sel(msg_sel),
    .msj_f(msj0), .idx(idx0), .busy(busy0), .done(done0), .wrap(wrap0)
  );

  msg_sequencer #(.CHAR_W(8), .MSG_LEN(6), .NUM_MSGS(2), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .M(M), .clr(clr), .msg_sel(msg_sel),
    .msj_f(msj1), .idx(idx1), .busy(busy1), .done(done1), .wrap(wrap1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Raise M, wait the three edges of latency, leave M low long enough to re-arm.
  task automatic press();
    @(negedge clk) M = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_m();
    @(negedge clk) M = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic soft_clear();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  logic [7:0] taller [6] = '{8'h54, 8'h41, 8'h4C, 8'h4C, 8'h45, 8'h52};

  initial begin
    // 1: reset values, then walk "TALLER" in one-shot mode
    #12;
    check("rst_msj", msj0, 8'h00);
    check("rst_idx", idx0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_wrap", wrap1, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    @(negedge clk) M = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("lat_early", msj0, 8'h00);
    @(posedge clk);
    #1 check("lat_on_time", msj0, 8'h54);
    check("t1_busy", busy0, 1);
    release_m();
    for (int i = 1; i < 6; i++) begin
      press();
      check($sformatf("t1_chr%0d", i), msj0, taller[i]);
      check($sformatf("t1_idx%0d", i), idx0, i);
      release_m();
    end
    press();
    check("t1_end", msj0, 8'hFF);
    check("t1_done", done0, 1);
    check("t1_idx_hold", idx0, 5);
    check("t1_end_busy", busy0, 0);
    release_m();
    press();
    check("t1_idle", msj0, 8'h00);
    check("t1_idle_done", done0, 0);
    release_m();

    // 2: selection latched on IDLE->SHOW only
    soft_clear();
    msg_sel = 1'b1;
    press();
    check("t2_first", msj0, 8'h46);
    release_m();
    msg_sel = 1'b0;
    press();
    check("t2_second", msj0, 8'h53);
    release_m();
    press();
    check("t2_third", msj0, 8'h4D);
    release_m();

    // 3: looping instance wraps after the last character
    soft_clear();
    for (int i = 0; i < 6; i++) begin
      press();
      release_m();
    end
    check("t3_last", msj1, 8'h52);
    check("t3_last_idx", idx1, 5);
    press();
    check("t3_wrap_chr", msj1, 8'h54);
    check("t3_wrap_idx", idx1, 0);
    check("t3_wrap_hi", wrap1, 1);
    check("t3_wrap_busy", busy1, 1);
    check("t3_oneshot_nowrap", wrap0, 0);
    check("t3_oneshot_done", done0, 1);
    @(posedge clk);
    #1 check("t3_wrap_lo", wrap1, 0);
    release_m();

    // 4: held button and glitches
    soft_clear();
    @(negedge clk) M = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("t4_hold_chr", msj0, 8'h54);
    check("t4_hold_idx", idx0, 0);
    release_m();
    @(negedge clk) M = 1'b1;
    @(negedge clk) M = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_glitch_chr", msj0, 8'h41);
    @(posedge clk);
    #1 M = 1'b1;
    #3 M = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_narrow_chr", msj0, 8'h41);

    // 5: asynchronous reset mid-message
    soft_clear();
    for (int i = 0; i < 4; i++) begin
      press();
      release_m();
    end
    check("t5_idx3", idx0, 3);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("t5_async_msj", msj0, 8'h00);
    check("t5_async_idx", idx0, 0);
    check("t5_async_busy", busy0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    press();
    check("t5_restart", msj0, 8'h54);
    release_m();

    // 6: clear wins over a simultaneous advance; held M does not re-trigger
    @(negedge clk) M = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1 check("t6_clr_msj", msj0, 8'h00);
    check("t6_clr_idx", idx0, 0);
    check("t6_clr_busy", busy0, 0);
    @(negedge clk) clr = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_retrigger", msj0, 8'h00);
    release_m();
    press();
    check("t6_restart", msj0, 8'h54);
    release_m();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
